burst_memory: RTL and testbench

Parametrised successor to the CHIP-8 main memory: synchronous RAM of 2^ADDR_W words × DATA_W bits with the existing single-cycle read/write port plus a burst engine that streams a contiguous block out of, or into, memory over valid/ready handshakes. The burst port serves Fx55/Fx65 register save/restore and Dxyn sprite fetches. A hardware clear sequence runs after every reset.

---
 rtl/burst_memory_if.sv | 43 ++++
 rtl/burst_memory.sv | 195 +++++++++++++++++++
 tb/tb_burst_memory.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/burst_memory_if.sv
// Bus bundle for burst_memory: direct read/write port, burst control,
// burst out/in streams and status. The memory side uses the slave modport,
// the requester (CPU or bench) uses the master modport.
interface burst_memory_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 4
) ();
  logic              read;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] read_data;
  logic              write;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              burst_start;
  logic              burst_dir;
  logic [ADDR_W-1:0] burst_addr;
  logic [LEN_W-1:0]  burst_len;
  logic [DATA_W-1:0] burst_out_data;
  logic              burst_out_valid;
  logic              burst_out_ready;
  logic [DATA_W-1:0] burst_in_data;
  logic              burst_in_valid;
  logic              burst_in_ready;
  logic              busy;
  logic              done;

  modport slave (
    input  read, read_addr, write, write_addr, write_data,
    input  burst_start, burst_dir, burst_addr, burst_len,
    input  burst_out_ready, burst_in_data, burst_in_valid,
    output read_data, burst_out_data, burst_out_valid, burst_in_ready,
    output busy, done
  );

  modport master (
    output read, read_addr, write, write_addr, write_data,
    output burst_start, burst_dir, burst_addr, burst_len,
    output burst_out_ready, burst_in_data, burst_in_valid,
    input  read_data, burst_out_data, burst_out_valid, burst_in_ready,
    input  busy, done
  );
endinterface

// File: rtl/burst_memory.sv
// burst_memory: 2^ADDR_W x DATA_W synchronous RAM with a direct read port,
// a direct write port and a burst engine streaming contiguous blocks out of
// or into memory over valid/ready. A clear sequence sweeps the whole array
// after every reset.
//
// Optional feature macro FONT_PRELOAD_EN: the clear sweep loads the 80-byte
// CHIP-8 hex font at 0x050-0x09F instead of zero (needs DATA_W >= 8 and
// DEPTH >= 160). Without it every word is cleared to zero.
//
// state | meaning
// CLEAR | sweeping addresses 0..DEPTH-1, one word per cycle
// IDLE  | waiting for burst_start, direct writes accepted
// BRD   | streaming memory -> burst_out
// BWR   | streaming burst_in -> memory, direct writes ignored
module burst_memory #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 12,
  parameter int LEN_W  = 4
) (
  input logic clk,
  input logic reset,
  burst_memory_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    BRD   = 2'd2,
    BWR   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q;        // clear address, or current burst address
  logic [ADDR_W-1:0] ptr_nxt;
  logic [LEN_W-1:0]  cnt_q;        // handshakes remaining minus one
  logic [DATA_W-1:0] out_data_q;
  logic [DATA_W-1:0] read_data_q;
  logic              done_q;
  logic              hs;
  logic              last;
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef FONT_PRELOAD_EN
  localparam logic [639:0] FONT = {
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,   // 0
    8'h20, 8'h60, 8'h20, 8'h20, 8'h70,   // 1
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,   // 2
    8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,   // 3
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,   // 4
    8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,   // 5
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,   // 6
    8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,   // 7
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,   // 8
    8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,   // 9
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,   // A
    8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,   // B
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,   // C
    8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,   // D
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,   // E
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80    // F
  };

  // Word written by the clear sweep: font byte inside 0x050-0x09F, else zero.
  function automatic logic [DATA_W-1:0] clear_word(input logic [ADDR_W-1:0] a);
    int idx;
    idx = int'(a) - 80;
    if (idx >= 0 && idx < 80)
      return DATA_W'(FONT[639 - 8*idx -: 8]);
    return '0;
  endfunction
`endif

  assign ptr_nxt = ptr_q + ADDR_W'(1);

  // State register; reset always restarts the clear sweep.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= CLEAR;
    else       state_q <= state_d;
  end

  // Next state, plus handshake and last-word detection for the datapath.
  always_comb begin
    state_d = state_q;
    hs      = 1'b0;
    last    = 1'b0;
    case (state_q)
      CLEAR: begin
        if (ptr_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (bus.burst_start) state_d = bus.burst_dir ? BWR : BRD;
      end
      BRD: begin
        hs = bus.burst_out_ready;
      end
      BWR: begin
        hs = bus.burst_in_valid;
      end
      default: state_d = CLEAR;
    endcase
    last = hs && (cnt_q == '0);
    if (last) state_d = IDLE;
  end

  // Single write port: the clear sweep, the burst-in stream, or the direct
  // write, depending on state. Direct writes lose in CLEAR and BWR.
  always_comb begin
    we = 1'b0;
    wa = '0;
    wd = '0;
    case (state_q)
      CLEAR: begin
        we = 1'b1;
        wa = ptr_q;
`ifdef FONT_PRELOAD_EN
        wd = clear_word(ptr_q);
`else
        wd = '0;
`endif
      end
      BWR: begin
        we = bus.burst_in_valid;
        wa = ptr_q;
        wd = bus.burst_in_data;
      end
      default: begin
        we = bus.write;
        wa = bus.write_addr;
        wd = bus.write_data;
      end
    endcase
  end

  // Memory array write; no reset, the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
  end

  // Direct read port, independent of the FSM; sees the pre-write word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         read_data_q <= '0;
    else if (bus.read) read_data_q <= mem[bus.read_addr];
  end

  // Burst datapath: address pointer, remaining count, out word and done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= last;
      case (state_q)
        CLEAR: ptr_q <= ptr_nxt;
        IDLE: begin
          if (bus.burst_start) begin
            ptr_q <= bus.burst_addr;
            cnt_q <= bus.burst_len;
            // Prefetch the first word so out_valid can rise next cycle.
            if (!bus.burst_dir) out_data_q <= mem[bus.burst_addr];
          end
        end
        BRD: begin
          if (hs) begin
            ptr_q      <= ptr_nxt;
            cnt_q      <= cnt_q - LEN_W'(1);
            out_data_q <= mem[ptr_nxt];
          end
        end
        BWR: begin
          if (hs) begin
            ptr_q <= ptr_nxt;
            cnt_q <= cnt_q - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.read_data       = read_data_q;
  assign bus.burst_out_data  = out_data_q;
  assign bus.burst_out_valid = (state_q == BRD);
  assign bus.burst_in_ready  = (state_q == BWR);
  assign bus.busy            = (state_q != IDLE);
  assign bus.done            = done_q;

endmodule

// File: tb/tb_burst_memory.sv
// Directed bench for burst_memory: table of direct read/write vectors plus
// hand-written burst, wrap and reset-abort sequences.
module tb_burst_memory;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   passed = 0;
  int   done_cnt = 0;

  burst_memory_if #(.DATA_W(8), .ADDR_W(12), .LEN_W(4)) bus ();

  burst_memory #(.DATA_W(8), .ADDR_W(12), .LEN_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.done) done_cnt++;

  typedef struct {
    logic        wr;
    logic [11:0] waddr;
    logic [7:0]  wdata;
    logic        rd;
    logic [11:0] raddr;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [16];

`ifdef FONT_PRELOAD_EN
  localparam logic [7:0] EXP_050 = 8'hF0;
  localparam logic [7:0] EXP_055 = 8'h20;
`else
  localparam logic [7:0] EXP_050 = 8'h00;
  localparam logic [7:0] EXP_055 = 8'h00;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      bus.write      = vecs[i].wr;
      bus.write_addr = vecs[i].waddr;
      bus.write_data = vecs[i].wdata;
      bus.read       = vecs[i].rd;
      bus.read_addr  = vecs[i].raddr;
      @(negedge clk);
      if (vecs[i].chk) check($sformatf("vec%0d_read_data", i), 32'(bus.read_data), 32'(vecs[i].exp));
    end
    bus.write = 1'b0;
    bus.read  = 1'b0;
  endtask

  task automatic dwrite(input logic [11:0] a, input logic [7:0] d);
    bus.write = 1'b1; bus.write_addr = a; bus.write_data = d;
    @(negedge clk);
    bus.write = 1'b0;
  endtask

  task automatic dread(input logic [11:0] a, input logic [7:0] exp, input string name);
    bus.read = 1'b1; bus.read_addr = a;
    @(negedge clk);
    bus.read = 1'b0;
    check(name, 32'(bus.read_data), 32'(exp));
  endtask

  task automatic wait_clear(input string name);
    int cycles = 0;
    while (bus.busy && cycles < 5000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    check(name, 32'(cycles), 32'd4096);
  endtask

  // Four-word write burst; in_valid optionally gapped every other cycle.
  task automatic burst_write(input logic [11:0] base, input logic [7:0] w0, input logic [7:0] w1,
                             input logic [7:0] w2, input logic [7:0] w3, input logic gapped);
    logic [7:0] words [4];
    int d0;
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    bus.burst_start = 1'b1; bus.burst_dir = 1'b1;
    bus.burst_addr = base; bus.burst_len = 4'd3; bus.burst_in_valid = 1'b0;
    @(negedge clk);
    bus.burst_start = 1'b0; bus.burst_addr = 12'h555; bus.burst_len = 4'd0;
    check("bwr_in_ready_rise", 32'(bus.burst_in_ready), 32'd1);
    d0 = done_cnt;
    for (int k = 0; k < 4; k++) begin
      bus.burst_in_valid = 1'b1; bus.burst_in_data = words[k];
      @(negedge clk);
      bus.burst_in_valid = 1'b0;
      if (k == 3) begin
        check("bwr_done_pulse", 32'(bus.done), 32'd1);
        check("bwr_in_ready_fall", 32'(bus.burst_in_ready), 32'd0);
        check("bwr_busy_fall", 32'(bus.busy), 32'd0);
      end else begin
        check("bwr_no_early_done", 32'(bus.done), 32'd0);
        if (gapped) @(negedge clk);
      end
    end
    @(negedge clk);
    check("bwr_done_once", 32'(done_cnt - d0), 32'd1);
  endtask

  // Four-word read burst with a ready pattern; checks order, stall hold, done.
  task automatic burst_read(input logic [11:0] base, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input logic [6:0] pat,
                            input logic poke_start, input string tag);
    logic [7:0] exp [4];
    logic [7:0] held = '0;
    logic stalled = 1'b0;
    int got = 0;
    int cyc = 0;
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    bus.burst_start = 1'b1; bus.burst_dir = 1'b0;
    bus.burst_addr = base; bus.burst_len = 4'd3; bus.burst_out_ready = 1'b0;
    @(negedge clk);
    bus.burst_start = 1'b0; bus.burst_addr = 12'h777; bus.burst_len = 4'd9;
    check({tag, "_valid_rise"}, 32'(bus.burst_out_valid), 32'd1);
    while (got < 4 && cyc < 40) begin
      bus.burst_out_ready = (cyc < 7) ? pat[6 - cyc] : 1'b1;
      if (poke_start) begin
        bus.burst_start = (cyc == 1 || cyc == 2);
        bus.burst_dir   = 1'b1;
      end
      if (stalled) check({tag, "_stall_hold"}, 32'(bus.burst_out_data), 32'(held));
      if (bus.burst_out_valid && bus.burst_out_ready) begin
        check($sformatf("%s_word%0d", tag, got), 32'(bus.burst_out_data), 32'(exp[got]));
        got++;
      end
      stalled = bus.burst_out_valid && !bus.burst_out_ready;
      held    = bus.burst_out_data;
      @(negedge clk);
      bus.burst_start = 1'b0;
      cyc++;
    end
    bus.burst_out_ready = 1'b0;
    check({tag, "_word_count"}, 32'(got), 32'd4);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_valid_fall"}, 32'(bus.burst_out_valid), 32'd0);
    check({tag, "_busy_fall"}, 32'(bus.busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_clear"}, 32'(bus.done), 32'd0);
  endtask

  initial begin
    int d0;
    //            wr    waddr    wdata  rd    raddr    chk   exp
    vecs[0]  = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h123, 1'b1, 8'h00};
    vecs[1]  = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h050, 1'b1, EXP_050};
    vecs[2]  = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h055, 1'b1, EXP_055};
    vecs[3]  = '{1'b1, 12'h200, 8'hA2, 1'b0, 12'h000, 1'b0, 8'h00};
    vecs[4]  = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h200, 1'b1, 8'hA2};
    vecs[5]  = '{1'b1, 12'h201, 8'h5C, 1'b1, 12'h201, 1'b1, 8'h00};
    vecs[6]  = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h201, 1'b1, 8'h5C};
    vecs[7]  = '{1'b0, 12'h000, 8'h00, 1'b0, 12'h200, 1'b1, 8'h5C};
    vecs[8]  = '{1'b1, 12'h202, 8'h77, 1'b1, 12'h200, 1'b1, 8'hA2};
    vecs[9]  = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h202, 1'b1, 8'h77};
    vecs[10] = '{1'b0, 12'h000, 8'h00, 1'b1, 12'hFFF, 1'b1, 8'h00};
    vecs[11] = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h300, 1'b1, 8'h11};
    vecs[12] = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h301, 1'b1, 8'h22};
    vecs[13] = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h302, 1'b1, 8'h33};
    vecs[14] = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h303, 1'b1, 8'h44};
    vecs[15] = '{1'b0, 12'h000, 8'h00, 1'b1, 12'h304, 1'b1, 8'h00};

    bus.read = 0; bus.read_addr = 0; bus.write = 0; bus.write_addr = 0; bus.write_data = 0;
    bus.burst_start = 0; bus.burst_dir = 0; bus.burst_addr = 0; bus.burst_len = 0;
    bus.burst_out_ready = 0; bus.burst_in_data = 0; bus.burst_in_valid = 0;

    repeat (3) @(negedge clk);
    check("rst_read_data", 32'(bus.read_data), 32'd0);
    check("rst_out_data", 32'(bus.burst_out_data), 32'd0);
    check("rst_out_valid", 32'(bus.burst_out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.burst_in_ready), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd1);

    reset = 1'b0;
    wait_clear("clear_cycles");
    run_vecs(0, 10);

    burst_write(12'h300, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    run_vecs(11, 15);

    burst_read(12'h300, 8'h11, 8'h22, 8'h33, 8'h44, 7'b1001101, 1'b0, "brd");

    dwrite(12'hFFE, 8'hAA);
    dwrite(12'hFFF, 8'hBB);
    dwrite(12'h000, 8'hCC);
    dwrite(12'h001, 8'hDD);
    burst_read(12'hFFE, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 7'b1101011, 1'b1, "wrap");
    check("wrap_start_ignored_idle", 32'(bus.busy), 32'd0);

    // Abort a write burst after two handshakes.
    d0 = done_cnt;
    bus.burst_start = 1'b1; bus.burst_dir = 1'b1;
    bus.burst_addr = 12'h400; bus.burst_len = 4'd5;
    @(negedge clk);
    bus.burst_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.burst_in_valid = 1'b1; bus.burst_in_data = 8'(8'h61 + k);
      @(negedge clk);
    end
    bus.burst_in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_in_ready", 32'(bus.burst_in_ready), 32'd0);
    check("abort_out_valid", 32'(bus.burst_out_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd1);
    check("abort_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    wait_clear("abort_clear_cycles");
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    dread(12'h400, 8'h00, "abort_rd_400");
    dread(12'h401, 8'h00, "abort_rd_401");
    dread(12'h200, 8'h00, "abort_rd_200");
    dread(12'h050, EXP_050, "abort_rd_050");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
